// File: rtl/addsub_digit_serial_if.sv
// Producer/consumer bundle for the digit-serial adder/subtracter.
// Start is taken only on an edge where Ready=1; Done pulses for one cycle when Res/Out/Ovf/Zero update.
interface addsub_digit_serial_if #(
    parameter int WIDTH = 16
);
    logic             Start;
    logic             Mode;
    logic [WIDTH-1:0] Input_1;
    logic [WIDTH-1:0] Input_2;
    logic             Ready;
    logic             Done;
    logic [WIDTH-1:0] Res;
    logic             Out;
    logic             Ovf;
    logic             Zero;

    modport master (
        output Start, Mode, Input_1, Input_2,
        input  Ready, Done, Res, Out, Ovf, Zero
    );

    modport slave (
        input  Start, Mode, Input_1, Input_2,
        output Ready, Done, Res, Out, Ovf, Zero
    );
endinterface

// File: rtl/addsub_digit_serial.sv
// Digit-serial A +/- B: one DIGIT-bit slice per cycle, LSB first, over WIDTH/DIGIT cycles.
// Subtraction is A + ~B + 1; Out is the raw carry out of bit WIDTH-1.
module addsub_digit_serial #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    addsub_digit_serial_if.slave bus,
    output logic                 dbg_state_o
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] res_q;
    logic [CW-1:0]    cnt_q;
    logic             carry_q;
    logic             out_q;
    logic             ovf_q;
    logic             zero_q;
    logic             done_q;

    logic [DIGIT:0]   dsum_d;
    logic [WIDTH-1:0] slice_d;
    logic [WIDTH-1:0] acc_d;
    logic             last_d;

    // The new slice enters at the top, so after N shifts slice 0 sits at the LSB.
    always_comb begin
        dsum_d  = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + (DIGIT+1)'(carry_q);
        slice_d = WIDTH'(dsum_d[DIGIT-1:0]);
        acc_d   = (acc_q >> DIGIT) | (slice_d << (WIDTH - DIGIT));
        last_d  = (cnt_q == CW'(N - 1));
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            out_q   <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.Start) begin
                        a_q     <= bus.Input_1;
                        b_q     <= bus.Input_2 ^ {WIDTH{bus.Mode}};
                        carry_q <= bus.Mode;
                        cnt_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    a_q     <= a_q >> DIGIT;
                    b_q     <= b_q >> DIGIT;
                    acc_q   <= acc_d;
                    carry_q <= dsum_d[DIGIT];
                    cnt_q   <= cnt_q + CW'(1);
                    // On the last slice the operand MSBs are still at the bottom of a_q/b_q.
                    if (last_d) begin
                        res_q   <= acc_d;
                        out_q   <= dsum_d[DIGIT];
                        ovf_q   <= (a_q[DIGIT-1] == b_q[DIGIT-1]) &&
                                   (dsum_d[DIGIT-1] != a_q[DIGIT-1]);
                        zero_q  <= (acc_d == '0);
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.Ready   = (state_q == IDLE);
    assign bus.Done    = done_q;
    assign bus.Res     = res_q;
    assign bus.Out     = out_q;
    assign bus.Ovf     = ovf_q;
    assign bus.Zero    = zero_q;
    assign dbg_state_o = state_q;
endmodule

// File: tb/tb_addsub_digit_serial.sv
// Bench for addsub_digit_serial: directed handshake/boundary cases on a 16/4 instance
// plus a random sweep of four other WIDTH/DIGIT instances against an arithmetic model.
module tb_addsub_digit_serial;
    localparam int MW = 16;
    localparam int MD = 4;
    localparam int MN = MW / MD;
    localparam int SW_W[4] = '{16, 16, 8, 32};
    localparam int SW_D[4] = '{1, 16, 2, 8};
    localparam int SW_OPS  = 1000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        sw_rst_n;
    logic        m_state;
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [18:0] exp_q[$];
    logic [15:0] prev_res;

    addsub_digit_serial_if #(.WIDTH(MW)) m_if ();

    addsub_digit_serial #(.WIDTH(MW), .DIGIT(MD)) dut (
        .Clk         (clk),
        .Rst_n       (rst_n),
        .bus         (m_if),
        .dbg_state_o (m_state)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain modular and signed arithmetic at width w.
    function automatic void model(input int w, input logic [63:0] a, input logic [63:0] b,
                                  input logic mode, output logic [63:0] res, output logic out,
                                  output logic ovf, output logic zero);
        logic [63:0] mask;
        longint      sa;
        longint      sb;
        longint      s;
        longint      lim;
        mask = (64'd1 << w) - 64'd1;
        sa   = a[w-1] ? longint'(a | ~mask) : longint'(a);
        sb   = b[w-1] ? longint'(b | ~mask) : longint'(b);
        lim  = longint'(1) <<< (w - 1);
        if (mode) begin
            res = (a - b) & mask;
            out = (a >= b);
            s   = sa - sb;
        end else begin
            res = (a + b) & mask;
            out = ((a + b) >> w) != 64'd0;
            s   = sa + sb;
        end
        ovf  = (s >= lim) || (s < -lim);
        zero = (res == 64'd0);
    endfunction

    task automatic check_reset_state(input string tag);
        check({tag, "_res"},   64'(m_if.Res),   64'd0);
        check({tag, "_out"},   64'(m_if.Out),   64'd0);
        check({tag, "_ovf"},   64'(m_if.Ovf),   64'd0);
        check({tag, "_zero"},  64'(m_if.Zero),  64'd0);
        check({tag, "_done"},  64'(m_if.Done),  64'd0);
        check({tag, "_ready"}, 64'(m_if.Ready), 64'd1);
    endtask

    // Called at a negedge; drives one request and returns at the negedge of its Done cycle.
    task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic mode,
                            input logic [18:0] exp);
        m_if.Start   = 1'b1;
        m_if.Mode    = mode;
        m_if.Input_1 = a;
        m_if.Input_2 = b;
        exp_q.push_back(exp);
        @(negedge clk);
        m_if.Start   = 1'b0;
        m_if.Input_1 = 16'($urandom);
        m_if.Input_2 = 16'($urandom);
        m_if.Mode    = 1'($urandom_range(0, 1));
        for (int k = 0; k < MN; k++) begin
            check("run_ready", 64'(m_if.Ready), 64'd0);
            check("run_done", 64'(m_if.Done), 64'd0);
            check("run_res_hold", 64'(m_if.Res), 64'(prev_res));
            @(negedge clk);
        end
        check("done_pulse", 64'(m_if.Done), 64'd1);
        check("done_ready", 64'(m_if.Ready), 64'd1);
        prev_res = exp[15:0];
    endtask

    task automatic hold_op(input logic [15:0] a, input logic [15:0] b, input logic mode,
                           input logic [18:0] exp);
        m_if.Start   = 1'b1;
        m_if.Mode    = mode;
        m_if.Input_1 = a;
        m_if.Input_2 = b;
        exp_q.push_back(exp);
        for (int k = 0; k < MN; k++) begin
            @(negedge clk);
            m_if.Input_1 = 16'($urandom);
            m_if.Input_2 = 16'($urandom);
            m_if.Mode    = 1'($urandom_range(0, 1));
            check("hold_ready", 64'(m_if.Ready), 64'd0);
        end
        @(negedge clk);
        m_if.Start = 1'b0;
        check("hold_done", 64'(m_if.Done), 64'd1);
        prev_res = exp[15:0];
    endtask

    task automatic reset_mid_run();
        m_if.Start   = 1'b1;
        m_if.Mode    = 1'b0;
        m_if.Input_1 = 16'h1111;
        m_if.Input_2 = 16'h2222;
        @(negedge clk);
        m_if.Start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        exp_q.delete();
        #1 check_reset_state("midrst");
        @(negedge clk);
        @(negedge clk);
        check_reset_state("midrst_hold");
        rst_n    = 1'b1;
        prev_res = 16'h0000;
        repeat (MN + 2) begin
            @(negedge clk);
            check("post_rst_done", 64'(m_if.Done), 64'd0);
        end
    endtask

    // Scoreboard for the 16/4 instance.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && m_if.Done === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                logic [18:0] e;
                e = exp_q.pop_front();
                check("res",  64'(m_if.Res),  64'(e[15:0]));
                check("out",  64'(m_if.Out),  64'(e[16]));
                check("ovf",  64'(m_if.Ovf),  64'(e[17]));
                check("zero", 64'(m_if.Zero), 64'(e[18]));
            end
        end
    end

    for (genvar g = 0; g < 4; g++) begin : sw
        localparam int W = SW_W[g];
        localparam int D = SW_D[g];
        localparam int N = W / D;
        logic s_state;
        logic fin;

        addsub_digit_serial_if #(.WIDTH(W)) s_if ();

        addsub_digit_serial #(.WIDTH(W), .DIGIT(D)) dut (
            .Clk         (clk),
            .Rst_n       (sw_rst_n),
            .bus         (s_if),
            .dbg_state_o (s_state)
        );

        initial begin
            logic [63:0] a;
            logic [63:0] b;
            logic [63:0] r;
            logic [63:0] mask;
            logic        m;
            logic        o;
            logic        v;
            logic        z;
            int          lat;
            fin          = 1'b0;
            s_if.Start   = 1'b0;
            s_if.Mode    = 1'b0;
            s_if.Input_1 = '0;
            s_if.Input_2 = '0;
            mask = (64'd1 << W) - 64'd1;
            wait (sw_rst_n === 1'b1);
            @(negedge clk);
            for (int i = 0; i < SW_OPS; i++) begin
                a = {$urandom, $urandom} & mask;
                b = {$urandom, $urandom} & mask;
                if ($urandom_range(0, 7) == 0) a = mask >> 1;
                if ($urandom_range(0, 7) == 0) b = mask;
                m = 1'($urandom_range(0, 1));
                s_if.Start   = 1'b1;
                s_if.Mode    = m;
                s_if.Input_1 = a[W-1:0];
                s_if.Input_2 = b[W-1:0];
                @(negedge clk);
                s_if.Start   = 1'b0;
                s_if.Input_1 = W'({$urandom, $urandom});
                lat = 0;
                while (s_if.Done !== 1'b1 && lat < N + 4) begin
                    @(negedge clk);
                    lat++;
                end
                model(W, a, b, m, r, o, v, z);
                check($sformatf("sw%0d_latency", g), 64'(lat), 64'(N));
                check($sformatf("sw%0d_res", g), 64'(s_if.Res), r);
                check($sformatf("sw%0d_out", g), 64'(s_if.Out), 64'(o));
                check($sformatf("sw%0d_ovf", g), 64'(s_if.Ovf), 64'(v));
                check($sformatf("sw%0d_zero", g), 64'(s_if.Zero), 64'(z));
            end
            fin = 1'b1;
        end
    end

    wire all_fin = sw[0].fin & sw[1].fin & sw[2].fin & sw[3].fin;

    initial begin
        logic [63:0] r;
        logic [15:0] a;
        logic [15:0] b;
        logic        m;
        logic        o;
        logic        v;
        logic        z;
        int          guard;
        rst_n        = 1'b0;
        sw_rst_n     = 1'b0;
        m_if.Start   = 1'b0;
        m_if.Mode    = 1'b0;
        m_if.Input_1 = 16'h0000;
        m_if.Input_2 = 16'h0000;
        prev_res     = 16'h0000;
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rst_n    = 1'b1;
        sw_rst_n = 1'b1;

        // {zero, ovf, out, res}
        start_op(16'h1234, 16'h4321, 1'b0, {1'b0, 1'b0, 1'b0, 16'h5555});
        start_op(16'h0005, 16'h0005, 1'b1, {1'b1, 1'b0, 1'b1, 16'h0000});
        start_op(16'h0003, 16'h0005, 1'b1, {1'b0, 1'b0, 1'b0, 16'hFFFE});
        start_op(16'h7FFF, 16'h0001, 1'b0, {1'b0, 1'b1, 1'b0, 16'h8000});
        start_op(16'hFFFF, 16'h0001, 1'b0, {1'b1, 1'b0, 1'b1, 16'h0000});
        start_op(16'h8000, 16'h0001, 1'b1, {1'b0, 1'b1, 1'b1, 16'h7FFF});
        hold_op(16'h0F0F, 16'h0101, 1'b0, {1'b0, 1'b0, 1'b0, 16'h1010});
        start_op(16'hA5A5, 16'h5A5A, 1'b1, {1'b0, 1'b1, 1'b1, 16'h4B4B});
        reset_mid_run();
        start_op(16'h0001, 16'hFFFF, 1'b1, {1'b0, 1'b0, 1'b0, 16'h0002});

        for (int i = 0; i < 100; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            m = 1'($urandom_range(0, 1));
            model(MW, 64'(a), 64'(b), m, r, o, v, z);
            start_op(a, b, m, {z, v, o, r[15:0]});
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        guard = 0;
        while (all_fin !== 1'b1 && guard < 40000) begin
            @(negedge clk);
            guard++;
        end
        check("sweep_finished", 64'(all_fin), 64'd1);
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
